// File: rtl/irq_pending_ctrl_if.sv
// Claim handshake between the pending controller and the interrupt consumer.
// master = controller side, slave = consumer side.
interface irq_pending_ctrl_if #(
   parameter int IDX_WIDTH = 3
);
   logic                 irq_req;
   logic [IDX_WIDTH-1:0] irq_idx;
   logic                 irq_ack;
   logic                 eoi;
   logic                 busy;

   modport master (
      output irq_req,
      output irq_idx,
      output busy,
      input  irq_ack,
      input  eoi
   );

   modport slave (
      input  irq_req,
      input  irq_idx,
      input  busy,
      output irq_ack,
      output eoi
   );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Edge-latching pending register feeding an external priority encoder, with a
// req/ack/eoi claim FSM. Define IRQ_PENDING_SYNC_EN to synchronize irq_in first.
module irq_pending_ctrl #(
   parameter int NUM_INPUTS = 8,
   parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] irq_in,
   input  logic [NUM_INPUTS-1:0] irq_mask,
   output logic [NUM_INPUTS-1:0] pending_out,
   input  logic [IDX_WIDTH-1:0]  enc_result,
   input  logic                  enc_valid,
   irq_pending_ctrl_if.master    claim
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      SERVICE
   } state_t;

   state_t                state;
   state_t                state_nx;
   logic [NUM_INPUTS-1:0] src;
   logic [NUM_INPUTS-1:0] prev;
   logic [NUM_INPUTS-1:0] pending;
   logic [NUM_INPUTS-1:0] edges;
   logic [NUM_INPUTS-1:0] clr;
   logic                  req_q;
   logic                  req_nx;
   logic [IDX_WIDTH-1:0]  idx_q;
   logic [IDX_WIDTH-1:0]  idx_nx;
   logic                  take;

`ifdef IRQ_PENDING_SYNC_EN
   logic [NUM_INPUTS-1:0] sync1;
   logic [NUM_INPUTS-1:0] sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= irq_in;
         sync2 <= sync1;
      end
   end

   assign src = sync2;
`else
   assign src = irq_in;
`endif

   assign edges = src & ~prev;
   assign clr   = take ? (NUM_INPUTS'(1) << idx_q) : '0;

   always_comb begin
      state_nx = state;
      req_nx   = req_q;
      idx_nx   = idx_q;
      take     = 1'b0;
      unique case (state)
         IDLE: begin
            if (enc_valid) begin
               idx_nx   = enc_result;
               req_nx   = 1'b1;
               state_nx = REQ;
            end
         end
         REQ: begin
            if (claim.irq_ack) begin
               take     = 1'b1;
               req_nx   = 1'b0;
               state_nx = SERVICE;
            end
         end
         SERVICE: begin
            if (claim.eoi) state_nx = IDLE;
         end
         default: begin
            req_nx   = 1'b0;
            state_nx = IDLE;
         end
      endcase
   end

   // A fresh edge on the bit being claimed survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev    <= '0;
         pending <= '0;
         state   <= IDLE;
         req_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         prev    <= src;
         pending <= (pending & ~clr) | edges;
         state   <= state_nx;
         req_q   <= req_nx;
         idx_q   <= idx_nx;
      end
   end

   assign pending_out   = pending & irq_mask;
   assign claim.irq_req = req_q;
   assign claim.irq_idx = idx_q;
   assign claim.busy    = (state != IDLE);

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model.
module tb_irq_pending_ctrl;

   localparam int N  = 8;
   localparam int IW = 3;
`ifdef IRQ_PENDING_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  irq_in = '0;
   logic [N-1:0]  irq_mask = 8'hFF;
   logic [N-1:0]  pending_out;
   logic [IW-1:0] enc_result;
   logic          enc_valid;

   int checks = 0;
   int errors = 0;

   irq_pending_ctrl_if #(.IDX_WIDTH(IW)) claim_if ();

   irq_pending_ctrl #(
      .NUM_INPUTS(N),
      .IDX_WIDTH (IW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .irq_mask   (irq_mask),
      .pending_out(pending_out),
      .enc_result (enc_result),
      .enc_valid  (enc_valid),
      .claim      (claim_if)
   );

   always #5 clk = ~clk;

   // Downstream priority encoder: highest set index wins.
   always_comb begin
      enc_valid  = |pending_out;
      enc_result = '0;
      for (int i = 0; i < N; i++)
         if (pending_out[i]) enc_result = IW'(i);
   end

   logic [N-1:0] m_pend;
   logic [N-1:0] m_prev;
   logic [N-1:0] m_s1;
   logic [N-1:0] m_s2;
   int           m_phase;
   logic         m_req;
   int           m_idx;

   function automatic int top(input logic [N-1:0] v);
      int r;
      r = 0;
      for (int i = 0; i < N; i++)
         if (v[i]) r = i;
      return r;
   endfunction

   task automatic model_reset();
      m_pend  = '0;
      m_prev  = '0;
      m_s1    = '0;
      m_s2    = '0;
      m_phase = 0;
      m_req   = 1'b0;
      m_idx   = 0;
   endtask

   task automatic model_step();
      logic [N-1:0] s;
      logic [N-1:0] e;
      logic [N-1:0] vis;
`ifdef IRQ_PENDING_SYNC_EN
      s    = m_s2;
      m_s2 = m_s1;
      m_s1 = irq_in;
`else
      s = irq_in;
`endif
      e      = s & ~m_prev;
      m_prev = s;
      vis    = m_pend & irq_mask;
      if (m_phase == 0) begin
         if (vis != 0) begin
            m_idx   = top(vis);
            m_req   = 1'b1;
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         if (claim_if.irq_ack) begin
            m_pend[m_idx] = 1'b0;
            m_req         = 1'b0;
            m_phase       = 2;
         end
      end else if (claim_if.eoi) begin
         m_phase = 0;
      end
      m_pend = m_pend | e;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check("pending_out", 32'(pending_out), 32'(m_pend & irq_mask));
      check("irq_req", 32'(claim_if.irq_req), 32'(m_req));
      check("irq_idx", 32'(claim_if.irq_idx), 32'(m_idx));
      check("busy", 32'(claim_if.busy), 32'(m_phase != 0));
   endtask

   task automatic run(input int n);
      repeat (n) cycle();
   endtask

   task automatic serve();
      claim_if.irq_ack = 1'b1;
      cycle();
      claim_if.irq_ack = 1'b0;
      claim_if.eoi     = 1'b1;
      cycle();
      claim_if.eoi     = 1'b0;
   endtask

   task automatic claim_is(input string name, input int idx);
      check({name, "_req"}, 32'(claim_if.irq_req), 32'd1);
      check({name, "_idx"}, 32'(claim_if.irq_idx), 32'(idx));
   endtask

   initial begin
      claim_if.irq_ack = 1'b0;
      claim_if.eoi     = 1'b0;
      model_reset();
      #1;
      check("rst_req", 32'(claim_if.irq_req), 32'd0);
      check("rst_busy", 32'(claim_if.busy), 32'd0);
      check("rst_pend", 32'(pending_out), 32'd0);
      run(2);
      rst_n = 1'b1;
      run(2);

      // single edge, latency
      irq_in = 8'h08;
      run(LAT - 1);
      check("single_pend", 32'(pending_out), 32'h08);
      check("single_noreq", 32'(claim_if.irq_req), 32'd0);
      cycle();
      claim_is("single", 3);
      claim_if.irq_ack = 1'b1;
      cycle();
      claim_if.irq_ack = 1'b0;
      check("single_clr", 32'(pending_out), 32'h00);
      check("single_busy", 32'(claim_if.busy), 32'd1);
      claim_if.eoi = 1'b1;
      cycle();
      claim_if.eoi = 1'b0;
      check("single_idle", 32'(claim_if.busy), 32'd0);
      irq_in = '0;
      run(LAT + 1);

      // simultaneous edges
      irq_in = 8'h42;
      run(LAT);
      claim_is("simul_first", 6);
      serve();
      cycle();
      claim_is("simul_second", 1);
      serve();
      irq_in = '0;
      run(LAT + 1);

      // masked line
      irq_mask = 8'hDF;
      irq_in   = 8'h20;
      run(LAT + 2);
      check("mask_noreq", 32'(claim_if.irq_req), 32'd0);
      check("mask_hidden", 32'(pending_out), 32'h00);
      irq_mask = 8'hFF;
      #1;
      check("mask_shown", 32'(pending_out), 32'h20);
      cycle();
      claim_is("mask", 5);
      serve();
      irq_in = '0;
      run(LAT + 1);

      // set and clear of the same bit collide
      irq_in = 8'h08;
      run(LAT);
      claim_is("collide_first", 3);
      irq_in = '0;
      run(LAT);
      irq_in           = 8'h08;
      claim_if.irq_ack = 1'b1;
      cycle();
      claim_if.irq_ack = 1'b0;
`ifndef IRQ_PENDING_SYNC_EN
      check("collide_kept", 32'(pending_out), 32'h08);
`endif
      claim_if.eoi = 1'b1;
      cycle();
      claim_if.eoi = 1'b0;
      run(LAT);
      claim_is("collide_again", 3);
      serve();
      irq_in = '0;
      run(LAT + 1);

      // claim held against higher-priority arrival
      irq_in = 8'h04;
      run(LAT);
      claim_is("hold_first", 2);
      irq_in = 8'h84;
      run(LAT + 1);
      claim_is("hold_kept", 2);
      serve();
      cycle();
      claim_is("hold_next", 7);
      serve();
      irq_in = '0;
      run(LAT + 1);

      // async reset mid-REQ, line high at release
      irq_in = 8'h01;
      run(LAT);
      claim_is("reset_pre", 0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("areset_req", 32'(claim_if.irq_req), 32'd0);
      check("areset_busy", 32'(claim_if.busy), 32'd0);
      check("areset_pend", 32'(pending_out), 32'd0);
      cycle();
      rst_n = 1'b1;
      run(LAT);
      claim_is("reset_post", 0);
      serve();
      irq_in = '0;
      run(LAT + 1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if ($urandom_range(0, 499) == 0) begin
            rst_n = 1'b0;
            model_reset();
         end
         irq_in = irq_in ^ N'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 15) == 0)
            irq_mask = N'($urandom);
         else if ($urandom_range(0, 15) == 0)
            irq_mask = 8'hFF;
         claim_if.irq_ack = ($urandom_range(0, 2) == 0);
         claim_if.eoi     = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
